// File: rtl/btn_step_ctrl.sv
// btn_step_ctrl: push-button conditioner for the up/down counter.
// The up, down and clear buttons are synchronized and debounced. The block
// turns them into a direction level (up_dn) and a one-cycle count strobe
// (step). Holding a direction button auto-repeats the strobe. A press of
// clear gives a one-cycle cnt_rst strobe.
`timescale 1ns/1ps

module btn_step_ctrl #(
    parameter int DB_CYCLES  = 1_000_000,
    parameter int REPEAT_DLY = 50_000_000,
    parameter int REPEAT_PER = 20_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_up,
    input  logic btn_dn,
    input  logic btn_clr,
    output logic step,
    output logic up_dn,
    output logic cnt_rst,
    output logic up_db,
    output logic dn_db,
    output logic clr_db
);

    localparam int DBW  = $clog2(DB_CYCLES);
    localparam int TMAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int TW   = $clog2(TMAX);

    localparam logic [DBW-1:0] DB_LAST  = DBW'(DB_CYCLES - 1);
    localparam logic [TW-1:0]  DLY_LAST = TW'(REPEAT_DLY - 1);
    localparam logic [TW-1:0]  PER_LAST = TW'(REPEAT_PER - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } state_e;

    // Bit order within each 3-bit vector: [0] up, [1] down, [2] clear.
    logic [2:0]     raw_s;
    logic [2:0]     sync1_q, sync1_d;
    logic [2:0]     sync2_q, sync2_d;
    logic [2:0]     db_q, db_d;
    logic [2:0]     db_prev_q, db_prev_d;
    logic [2:0]     rise_s;
    logic [DBW-1:0] db_cnt_q [3];
    logic [DBW-1:0] db_cnt_d [3];

    state_e         state_q, state_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic           step_q, step_d;
    logic           up_dn_q, up_dn_d;
    logic           cnt_rst_q, cnt_rst_d;
    logic           active_s;
    logic           other_s;

    assign raw_s  = {btn_clr, btn_dn, btn_up};
    assign rise_s = db_q & ~db_prev_q;

    // Two-stage synchronizer and per-button debounce counters.
    always_comb begin
        sync1_d   = raw_s;
        sync2_d   = sync1_q;
        db_prev_d = db_q;
        db_d      = db_q;
        for (int i = 0; i < 3; i++) begin
            db_cnt_d[i] = db_cnt_q[i];
            if (sync2_q[i] == db_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DB_LAST) begin
                db_d[i]     = sync2_q[i];
                db_cnt_d[i] = '0;
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + DBW'(1);
            end
        end
    end

    // Step FSM: press acceptance, hold delay, auto-repeat, and clear override.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        up_dn_d   = up_dn_q;
        step_d    = 1'b0;
        cnt_rst_d = rise_s[2];
        // The button that started the current press, and the opposite one.
        active_s  = up_dn_q ? db_q[0] : db_q[1];
        other_s   = up_dn_q ? db_q[1] : db_q[0];

        if (db_q[2]) begin
            // While clear is held, counting is stopped and any press is abandoned.
            state_d = ST_IDLE;
            timer_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // A press counts only if the other direction is not down.
                    if (rise_s[0] && !db_q[1]) begin
                        step_d  = 1'b1;
                        up_dn_d = 1'b1;
                        timer_d = '0;
                        state_d = ST_HOLD;
                    end else if (rise_s[1] && !db_q[0]) begin
                        step_d  = 1'b1;
                        up_dn_d = 1'b0;
                        timer_d = '0;
                        state_d = ST_HOLD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_HOLD, ST_REPEAT: begin
                    // Release and conflict take priority over a due repeat strobe.
                    if (!active_s || other_s) begin
                        state_d = ST_IDLE;
                        timer_d = '0;
                    end else if (timer_q == ((state_q == ST_HOLD) ? DLY_LAST : PER_LAST)) begin
                        step_d  = 1'b1;
                        timer_d = '0;
                        state_d = ST_REPEAT;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= 3'b000;
            sync2_q   <= 3'b000;
            db_q      <= 3'b000;
            db_prev_q <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                db_cnt_q[i] <= '0;
            end
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            step_q    <= 1'b0;
            up_dn_q   <= 1'b1;
            cnt_rst_q <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            db_q      <= db_d;
            db_prev_q <= db_prev_d;
            for (int i = 0; i < 3; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
            state_q   <= state_d;
            timer_q   <= timer_d;
            step_q    <= step_d;
            up_dn_q   <= up_dn_d;
            cnt_rst_q <= cnt_rst_d;
        end
    end

    assign step    = step_q;
    assign up_dn   = up_dn_q;
    assign cnt_rst = cnt_rst_q;
    assign up_db   = db_q[0];
    assign dn_db   = db_q[1];
    assign clr_db  = db_q[2];

endmodule

// File: tb/tb_btn_step_ctrl.sv
// Directed bench for btn_step_ctrl with DB_CYCLES=4, REPEAT_DLY=10, REPEAT_PER=5.
// Inputs change on the falling edge. Outputs are sampled on the falling edge
// after each rising edge. Within each scenario, c counts the rising edges
// since the stimulus began.
`timescale 1ns/1ps

module tb_btn_step_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic btn_up, btn_dn, btn_clr;
    logic step, up_dn, cnt_rst, up_db, dn_db, clr_db;

    int errors = 0;
    int checks = 0;

    btn_step_ctrl #(
        .DB_CYCLES  (4),
        .REPEAT_DLY (10),
        .REPEAT_PER (5)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .btn_up  (btn_up),
        .btn_dn  (btn_dn),
        .btn_clr (btn_clr),
        .step    (step),
        .up_dn   (up_dn),
        .cnt_rst (cnt_rst),
        .up_db   (up_db),
        .dn_db   (dn_db),
        .clr_db  (clr_db)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        btn_up  = 1'b0;
        btn_dn  = 1'b0;
        btn_clr = 1'b0;
        for (int k = 0; k < n; k++) cyc();
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        logic exp_s;

        // Reset held for three cycles while the buttons toggle.
        rst = 1'b1;
        btn_up = 1'b0; btn_dn = 1'b0; btn_clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            btn_up  = i[0];
            btn_dn  = ~i[0];
            btn_clr = i[1];
            cyc();
        end
        check("rst step", step, 1'b0);
        check("rst cnt_rst", cnt_rst, 1'b0);
        check("rst up_dn", up_dn, 1'b1);
        check("rst up_db", up_db, 1'b0);
        check("rst dn_db", dn_db, 1'b0);
        check("rst clr_db", clr_db, 1'b0);
        rst = 1'b0;
        btn_up = 1'b0; btn_dn = 1'b0; btn_clr = 1'b0;
        for (int c = 1; c <= 2; c++) begin
            cyc();
            check($sformatf("post-rst step c%0d", c), step, 1'b0);
            check($sformatf("post-rst cnt_rst c%0d", c), cnt_rst, 1'b0);
        end
        idle(10);

        // Single up press lasting 8 cycles: one step at cycle 7, no repeat.
        btn_up = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            cyc();
            check($sformatf("single step c%0d", c), step, (c == 7));
            check($sformatf("single up_db c%0d", c), up_db, (c >= 6 && c <= 13));
            check($sformatf("single cnt_rst c%0d", c), cnt_rst, 1'b0);
            if (c == 7) check("single up_dn", up_dn, 1'b1);
            if (c == 8) btn_up = 1'b0;
        end
        idle(12);

        // Down button bouncing (3 high, 3 low) for 30 cycles, then stable high.
        for (int c = 0; c < 30; c++) begin
            btn_dn = ((c / 3) % 2 == 0);
            cyc();
            check($sformatf("bounce step c%0d", c), step, 1'b0);
            check($sformatf("bounce dn_db c%0d", c), dn_db, 1'b0);
        end
        btn_dn = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            cyc();
            check($sformatf("bounce-settle step c%0d", c), step, (c == 7));
            if (c == 7) check("bounce up_dn", up_dn, 1'b0);
            if (c == 8) btn_dn = 1'b0;
        end
        idle(12);

        // Up button held for 40 cycles: steps at 7, 17, then every 5 cycles.
        btn_up = 1'b1;
        for (int c = 1; c <= 55; c++) begin
            cyc();
            exp_s = (c == 7) || (c == 17) || (c >= 22 && c <= 42 && ((c - 22) % 5 == 0));
            check($sformatf("repeat step c%0d", c), step, exp_s);
            if (exp_s) check($sformatf("repeat up_dn c%0d", c), up_dn, 1'b1);
            if (c == 40) btn_up = 1'b0;
        end
        idle(12);

        // Up held, and down pressed during repeat: repeats stop once dn_db rises.
        btn_up = 1'b1;
        for (int c = 1; c <= 50; c++) begin
            cyc();
            exp_s = (c == 7) || (c == 17) || (c == 22) || (c == 27);
            check($sformatf("both step c%0d", c), step, exp_s);
            check($sformatf("both dn_db c%0d", c), dn_db, (c >= 29));
            if (c == 23) btn_dn = 1'b1;
        end
        idle(12);

        // Clear pressed during auto-repeat. Up stays held past the clear, then
        // is released and pressed again.
        btn_up = 1'b1;
        for (int c = 1; c <= 70; c++) begin
            cyc();
            exp_s = (c == 7) || (c == 17) || (c == 22) || (c == 27) || (c == 67);
            check($sformatf("clr step c%0d", c), step, exp_s);
            check($sformatf("clr cnt_rst c%0d", c), cnt_rst, (c == 30));
            check($sformatf("clr clr_db c%0d", c), clr_db, (c >= 29 && c <= 40));
            if (c == 23) btn_clr = 1'b1;
            if (c == 35) btn_clr = 1'b0;
            if (c == 50) btn_up = 1'b0;
            if (c == 60) btn_up = 1'b1;
        end
        idle(12);

        // Reset during a hold with up still pressed: debounced afresh, new first step.
        btn_up = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            cyc();
            check($sformatf("midrst pre step c%0d", c), step, (c == 7) || (c == 17));
        end
        rst = 1'b1;
        cyc();
        cyc();
        check("midrst step", step, 1'b0);
        check("midrst up_db", up_db, 1'b0);
        check("midrst up_dn", up_dn, 1'b1);
        check("midrst cnt_rst", cnt_rst, 1'b0);
        rst = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            cyc();
            check($sformatf("midrst post step c%0d", c), step, (c == 7));
            check($sformatf("midrst post up_db c%0d", c), up_db, (c >= 6));
        end
        idle(12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
